i2c_bus_arbiter: RTL and testbench

//  Shares the single audio-subsystem i2c_master between NUM_REQ command sources (codec init, status poller,

---
 rtl/aud_i2c_pkg.sv | 31 +++
 rtl/i2c_bus_arbiter_rr_pick.sv | 39 +++
 rtl/i2c_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_i2c_pkg.sv
// Shared definitions for the audio-subsystem I2C arbiter.
//   - arb_state_t   : arbiter FSM state encoding
//   - I2C_DATA_W    : default I2C data / register-address width
//   - I2C_ADDR_W    : default I2C device-address width
//   - onehot_to_idx : one-hot (up to 8 bits) to binary index
package aud_i2c_pkg;

  localparam int I2C_DATA_W = 8;
  localparam int I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_ABORT     = 3'd4,
    ST_RELEASE   = 3'd5
  } arb_state_t;

  // OR-reduction of the set bit positions; exact for a one-hot input and
  // avoids building a priority chain.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Round-robin picker (combinational).
//   req        : request vector
//   rr_ptr     : index with highest priority this round
//   winner_oh  : one-hot winner, all-zero when no request
//   winner_idx : binary index of the winner (0 when no request)
//   valid      : at least one request present
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  assign valid = |req;

  // Scan offsets from the farthest down to zero so the nearest requester
  // at or after rr_ptr is the last (and therefore winning) assignment.
  always_comb begin
    cand       = '0;
    winner_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
      if (req[cand[IDX_W-1:0]]) winner_idx = cand[IDX_W-1:0];
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_oh
    assign winner_oh[gi] = valid && (winner_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ command sources.
// One complete I2C transaction per grant; the winner's command is latched,
// the master's enable/busy handshake is driven, and a one-cycle done (or err
// on timeout) is returned to the owner together with read data.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req, req_rw                       per-requester level request / read flag
//   req_dev, req_reg, req_wdata       packed per-requester command fields
//   grant, done, err                  one-hot owner, completion / timeout pulses
//   rdata                             read data, updated on a read's done
//   m_enable, m_rw, m_dev, m_reg,
//   m_wdata                           registered command to i2c_master
//   m_busy, m_rdata                   status / read data from i2c_master
module i2c_bus_arbiter
  import aud_i2c_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = I2C_DATA_W,
  parameter int ADDR_W      = I2C_ADDR_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dev,
  input  logic [NUM_REQ*DATA_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic                      m_enable,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_dev,
  output logic [DATA_W-1:0]         m_reg,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_busy,
  input  logic [DATA_W-1:0]         m_rdata
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

  arb_state_t          state_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [IDX_W-1:0]    owner_idx;
  logic [IDX_W-1:0]    rr_ptr_next;
  logic [TIMER_W-1:0]  timer_inc;

  logic [ADDR_W-1:0]   dev_arr   [NUM_REQ];
  logic [DATA_W-1:0]   reg_arr   [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign dev_arr[gi]   = req_dev[gi*ADDR_W +: ADDR_W];
    assign reg_arr[gi]   = req_reg[gi*DATA_W +: DATA_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_reg),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // grant is held one-hot for the whole transaction, so it doubles as the
  // owner record.
  assign owner_idx   = IDX_W'(onehot_to_idx(8'(grant)));
  assign rr_ptr_next = (owner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
  assign timer_inc   = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      rr_ptr_reg <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= '0;
      rdata      <= '0;
      m_enable   <= 1'b0;
      m_rw       <= 1'b0;
      m_dev      <= '0;
      m_reg      <= '0;
      m_wdata    <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            m_rw      <= req_rw[pick_idx];
            m_dev     <= dev_arr[pick_idx];
            m_reg     <= reg_arr[pick_idx];
            m_wdata   <= wdata_arr[pick_idx];
            grant     <= pick_oh;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          m_enable  <= 1'b1;
          timer_reg <= '0;
          state_reg <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (m_busy) begin
            m_enable  <= 1'b0;
            timer_reg <= '0;
            state_reg <= ST_WAIT_IDLE;
          end else if (timer_reg == TIMER_LAST) begin
            m_enable  <= 1'b0;
            state_reg <= ST_ABORT;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_WAIT_IDLE: begin
          if (!m_busy) begin
            if (m_rw) rdata <= m_rdata;
            done      <= grant;
            state_reg <= ST_RELEASE;
          end else if (timer_reg == TIMER_LAST) begin
            state_reg <= ST_ABORT;
          end else begin
            timer_reg <= timer_inc;
          end
        end
        ST_ABORT: begin
          err       <= grant;
          state_reg <= ST_RELEASE;
        end
        ST_RELEASE: begin
          grant      <= '0;
          rr_ptr_reg <= rr_ptr_next;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_rw;
  logic [N*AW-1:0] req_dev;
  logic [N*DW-1:0] req_reg, req_wdata;
  logic [N-1:0]    grant, done, err;
  logic [DW-1:0]   rdata;
  logic            m_enable, m_rw;
  logic [AW-1:0]   m_dev;
  logic [DW-1:0]   m_reg, m_wdata;
  logic            m_busy;
  logic [DW-1:0]   m_rdata;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_dev(req_dev),
    .req_reg(req_reg), .req_wdata(req_wdata), .grant(grant), .done(done),
    .err(err), .rdata(rdata), .m_enable(m_enable), .m_rw(m_rw), .m_dev(m_dev),
    .m_reg(m_reg), .m_wdata(m_wdata), .m_busy(m_busy), .m_rdata(m_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Slave register contents seen through the master.
  function automatic logic [7:0] slave_val(input logic [7:0] r);
    return (r == 8'h43) ? 8'hA5 : (r ^ 8'h3C);
  endfunction

  // ---------------- behavioural i2c_master ----------------
  int         busy_delay = 0, busy_len = 2;
  bit         never_busy = 0, rand_timing = 0;
  int         mphase, mcnt;
  logic [7:0] mlat_reg;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_rdata <= '0; mphase <= 0; mcnt <= 0; mlat_reg <= '0;
    end else begin
      case (mphase)
        0: if (m_enable && !never_busy) begin
             mcnt     <= rand_timing ? int'($urandom_range(0, 3)) : busy_delay;
             mlat_reg <= m_reg;
             mphase   <= 1;
           end
        1: if (mcnt == 0) begin
             m_busy <= 1'b1;
             mcnt   <= rand_timing ? int'($urandom_range(0, 6)) : busy_len;
             mphase <= 2;
           end else mcnt <= mcnt - 1;
        default: if (mcnt == 0) begin
             m_busy  <= 1'b0;
             m_rdata <= slave_val(mlat_reg);
             mphase  <= 0;
           end else mcnt <= mcnt - 1;
      endcase
    end
  end

  // ---------------- transaction-level reference model / monitor ----------------
  function automatic int rr_model(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  int         ptr_m = 0, owner_m = 0, txn_count = 0;
  logic [N-1:0] prev_grant = '0, prev_req = '0;
  bit         prev_rst = 1, prev_en = 0;
  bit         exp_rw;
  logic [6:0] exp_dev;
  logic [7:0] exp_reg, exp_wd, exp_rdata_m = '0;

  always @(negedge clk) begin
    if (rst) begin
      ptr_m = 0; exp_rdata_m = '0; prev_rst = 1; prev_grant = '0; prev_en = 0;
      prev_req = req;
    end else begin
      check("grant_onehot", 32'($countones(grant) <= 1), 1);
      if (!prev_rst && prev_grant == '0) begin
        if (prev_req != '0) begin
          owner_m = rr_model(prev_req, ptr_m);
          check("arb_winner", grant, 32'(1) << owner_m);
          exp_rw  = req_rw[owner_m];
          exp_dev = req_dev[owner_m*AW +: AW];
          exp_reg = req_reg[owner_m*DW +: DW];
          exp_wd  = req_wdata[owner_m*DW +: DW];
        end else check("no_spurious_grant", grant, 0);
      end
      if (m_enable && !prev_en) begin
        check("cmd", {m_rw, m_dev, m_reg, m_wdata}, {exp_rw, exp_dev, exp_reg, exp_wd});
        check("enable_while_busy", m_busy, 0);
      end
      if (done != '0 || err != '0) begin
        check("resp_owner", done | err, 32'(1) << owner_m);
        check("resp_kind", err != '0, never_busy);
        if (done != '0 && exp_rw) exp_rdata_m = slave_val(exp_reg);
        ptr_m = (owner_m + 1) % N;
        txn_count++;
      end
      check("rdata_hold", rdata, exp_rdata_m);
      prev_rst = 0; prev_grant = grant; prev_req = req; prev_en = m_enable;
    end
  end

  // ---------------- helpers ----------------
  task automatic set_cmd(input int i, input bit rw, input logic [6:0] d,
                         input logic [7:0] r, input logic [7:0] w);
    req_rw[i] = rw;
    req_dev[i*AW +: AW]   = d;
    req_reg[i*DW +: DW]   = r;
    req_wdata[i*DW +: DW] = w;
  endtask

  // what: 0=m_enable, 1=m_busy, 2=done|err, 3=grant!=0. Ends on that negedge.
  task automatic wait_ev(input int what, input int limit, input string name);
    bit hit = 0;
    for (int k = 0; k < limit && !hit; k++) begin
      @(negedge clk);
      case (what)
        0: hit = m_enable;
        1: hit = m_busy;
        2: hit = (done | err) != '0;
        default: hit = grant != '0;
      endcase
    end
    check(name, hit, 1);
  endtask

  task automatic do_reset();
    req = '0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  typedef struct {
    int idx; bit rw; logic [6:0] dev; logic [7:0] rg; logic [7:0] wd;
    int dly; int len; bit nb; bit exp_err; logic [7:0] exp_rdata;
  } vec_t;
  vec_t tbl[6];

  int lat, cnt, ng;
  int gseq[6];
  logic [N-1:0] g_last;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // ---------------- random requesters ----------------
  task automatic random_phase(input int cycles);
    rand_timing = 1; never_busy = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && (done[i] || err[i])) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_cmd(i, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 60 && req != '0; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (done[i] || err[i]) req[i] = 1'b0;
    end
    check("random_drained", req, 0);
    rand_timing = 0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_rw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;

    tbl[0] = '{0, 1'b0, 7'h18, 8'h41, 8'h30, 0, 3, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1, 1'b1, 7'h18, 8'h43, 8'h00, 1, 4, 1'b0, 1'b0, 8'hA5};
    tbl[2] = '{2, 1'b0, 7'h20, 8'h10, 8'h55, 2, 2, 1'b0, 1'b0, 8'hA5};
    tbl[3] = '{0, 1'b1, 7'h1A, 8'h05, 8'h00, 0, 1, 1'b0, 1'b0, 8'h39};
    tbl[4] = '{2, 1'b1, 7'h18, 8'hFF, 8'h00, 3, 5, 1'b0, 1'b0, 8'hC3};
    tbl[5] = '{1, 1'b1, 7'h30, 8'h22, 8'h00, 0, 0, 1'b1, 1'b1, 8'hC3};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0); check("rst_done", done, 0); check("rst_err", err, 0);
    check("rst_m_enable", m_enable, 0); check("rst_m_cmd", {m_rw, m_dev, m_reg, m_wdata}, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      never_busy = tbl[v].nb; busy_delay = tbl[v].dly; busy_len = tbl[v].len;
      set_cmd(tbl[v].idx, tbl[v].rw, tbl[v].dev, tbl[v].rg, tbl[v].wd);
      req[tbl[v].idx] = 1'b1;
      @(negedge clk);
      lat = 0;
      for (int k = 1; k <= 10 && lat == 0; k++) begin
        @(negedge clk);
        if (m_enable) lat = k;
      end
      check("enable_latency", lat, 2);
      wait_ev(2, 100, "vec_resp_seen");
      check("vec_done", done, tbl[v].exp_err ? 0 : (32'(1) << tbl[v].idx));
      check("vec_err", err, tbl[v].exp_err ? (32'(1) << tbl[v].idx) : 0);
      check("vec_rdata", rdata, tbl[v].exp_rdata);
      @(posedge clk); #1; req[tbl[v].idx] = 1'b0;
      @(negedge clk);
      check("resp_one_cycle", done | err, 0);
      never_busy = 0;
      repeat (3) @(posedge clk);
    end

    // Reset during WAIT_IDLE (rdata is 0xC3, m_* nonzero before reset)
    @(posedge clk); #1;
    busy_delay = 0; busy_len = 30;
    set_cmd(0, 1'b1, 7'h18, 8'h43, 8'h00); req[0] = 1'b1;
    wait_ev(1, 20, "rstmid_busy_seen");
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; req = '0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rstmid_grant", grant, 0); check("rstmid_m_enable", m_enable, 0);
    check("rstmid_m_cmd", {m_rw, m_dev, m_reg, m_wdata}, 0); check("rstmid_rdata", rdata, 0);
    cnt = 0;
    repeat (5) begin @(negedge clk); if ((done | err) != '0) cnt++; end
    check("rstmid_no_resp", cnt, 0);
    @(posedge clk); #1;
    busy_len = 2; set_cmd(1, 1'b0, 7'h11, 8'h22, 8'h33); req[1] = 1'b1;
    wait_ev(2, 60, "rstmid_new_resp");
    check("rstmid_new_done", done, 3'b010);
    @(posedge clk); #1; req = '0;
    repeat (3) @(posedge clk);

    // Timeout in WAIT_BUSY; rr pointer then at 2
    #1; never_busy = 1;
    set_cmd(1, 1'b0, 7'h0C, 8'h01, 8'h02); req[1] = 1'b1;
    wait_ev(0, 10, "to_enable_seen");
    cnt = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_enable) cnt++; else break;
    end
    check("to_enable_cycles", cnt, TO);
    check("to_err_not_yet", err, 0);
    @(negedge clk);
    check("to_err_pulse", err, 3'b010);
    @(posedge clk); #1; never_busy = 0; busy_len = 2;
    set_cmd(0, 1'b0, 7'h01, 8'h02, 8'h03);
    set_cmd(2, 1'b0, 7'h05, 8'h06, 8'h07);
    req = 3'b111;
    wait_ev(3, 10, "to_next_grant_seen");
    check("to_rr_advanced", grant, 3'b100);

    // All three held: order 0,1,2,0,1,2 after reset
    @(posedge clk); #1; do_reset();
    busy_delay = 1; busy_len = 2; req = 3'b111;
    ng = 0; g_last = '0;
    for (int k = 0; k < 400 && ng < 6; k++) begin
      @(negedge clk);
      if (grant != '0 && g_last == '0) begin
        gseq[ng] = (grant == 3'b001) ? 0 : (grant == 3'b010) ? 1 : (grant == 3'b100) ? 2 : 9;
        ng++;
      end
      g_last = grant;
    end
    check("rr_grant_count", ng, 6);
    for (int k = 0; k < 6; k++) check("rr_order", gseq[k], k % 3);
    @(posedge clk); #1; req = '0;
    wait_ev(2, 60, "rr_final_resp");
    repeat (3) @(posedge clk);

    // Requester 2 drops req mid-transaction; rr pointer wraps to 0
    #1; do_reset();
    busy_delay = 0; busy_len = 2;
    set_cmd(0, 1'b0, 7'h18, 8'h41, 8'h30); req[0] = 1'b1;
    wait_ev(2, 60, "drop_pre_resp");
    @(posedge clk); #1; req = '0;
    repeat (2) @(posedge clk); #1;
    busy_len = 10;
    set_cmd(2, 1'b1, 7'h18, 8'h10, 8'h00); req[2] = 1'b1;
    wait_ev(1, 20, "drop_busy_seen");
    @(posedge clk); #1; req[2] = 1'b0;
    wait_ev(2, 60, "drop_resp_seen");
    check("drop_done", done, 3'b100);
    check("drop_rdata", rdata, 8'h2C);
    @(posedge clk); #1; busy_len = 2; req = 3'b111;
    wait_ev(3, 10, "drop_next_grant_seen");
    check("drop_rr_wrapped", grant, 3'b001);
    @(posedge clk); #1; req = '0;
    wait_ev(2, 60, "drop_final_resp");
    repeat (3) @(posedge clk); #1;

    // Randomized traffic against the monitor's reference model
    cnt = txn_count;
    random_phase(1500);
    check("random_txns", 32'((txn_count - cnt) >= 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
